// File: rtl/sram_sp_banked.sv
// Banked single-port SRAM model with byte enables, request/grant handshake and a
// post-reset hardware clear. Define SRAM_OUT_REG_EN to add an output pipeline register.
module sram_sp_banked #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 2048,
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ,
    input  logic                WE,
    input  logic [ADDR_W-1:0]   A,
    input  logic [DATA_W-1:0]   D,
    input  logic [DATA_W/8-1:0] BE,
    output logic                GNT,
    output logic [DATA_W-1:0]   Q,
    output logic                QVALID,
    output logic                INIT_DONE
);

    localparam int NB        = DATA_W / 8;
    localparam int ROWS      = DEPTH / NUM_BANKS;
    localparam int ROW_SHIFT = $clog2(ROWS);
    localparam int ROW_W     = (ROWS > 1) ? ROW_SHIFT : 1;
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              init_done_q, init_done_d;

    // Array-side access, muxed between the clear sequence and granted requests.
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_be;

    logic [BANK_W-1:0] sel_bank;
    logic [ROW_W-1:0]  sel_row;

    logic              rd_fire;
    logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
    logic              rvalid_q, rvalid_d;
    logic              q_zero_q, q_zero_d;
    logic [DATA_W-1:0] rd_data;

    logic [NUM_BANKS-1:0][DATA_W-1:0] bank_rdata;

    assign GNT       = REQ & init_done_q;
    assign INIT_DONE = init_done_q;
    assign rd_fire   = GNT & ~WE;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        mem_en      = 1'b0;
        mem_we      = WE;
        mem_addr    = A;
        mem_wdata   = D;
        mem_be      = BE;
        unique case (state_q)
            ST_CLEAR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q;
                mem_wdata = '0;
                mem_be    = '1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d     = ST_READY;
                    init_done_d = 1'b1;
                end
            end
            ST_READY: begin
                mem_en = GNT;
            end
        endcase
    end

    assign sel_bank = BANK_W'(mem_addr >> ROW_SHIFT);
    assign sel_row  = ROW_W'(mem_addr & ADDR_W'(ROWS - 1));

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        // NOTE: the array has no reset; the clear sequence zeroes it so it maps onto a macro.
        logic [DATA_W-1:0] mem [ROWS];
        logic              bank_en;
        logic [DATA_W-1:0] rdata_q, rdata_d;

        assign bank_en = mem_en && (sel_bank == BANK_W'(b));

        always_comb begin
            rdata_d = rdata_q;
            if (bank_en && !mem_we) begin
                rdata_d = mem[sel_row];
            end
        end

        always_ff @(posedge CLK) begin
            rdata_q <= rdata_d;
            if (bank_en && mem_we) begin
                for (int i = 0; i < NB; i++) begin
                    if (mem_be[i]) begin
                        mem[sel_row][8*i +: 8] <= mem_wdata[8*i +: 8];
                    end
                end
            end
        end

        assign bank_rdata[b] = rdata_q;
    end

    // The macro outputs cannot be reset, so Q is masked to zero until the first read after reset.
    always_comb begin
        rd_bank_d = rd_fire ? sel_bank : rd_bank_q;
        rvalid_d  = rd_fire;
        q_zero_d  = q_zero_q & ~rd_fire;
    end

    assign rd_data = q_zero_q ? '0 : bank_rdata[rd_bank_q];

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            rd_bank_q   <= '0;
            rvalid_q    <= 1'b0;
            q_zero_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            rd_bank_q   <= rd_bank_d;
            rvalid_q    <= rvalid_d;
            q_zero_q    <= q_zero_d;
        end
    end

`ifdef SRAM_OUT_REG_EN
    logic [DATA_W-1:0] q_q, q_d;
    logic              qvalid_q, qvalid_d;

    always_comb begin
        qvalid_d = rvalid_q;
        q_d      = rvalid_q ? rd_data : q_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q      <= '0;
            qvalid_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            qvalid_q <= qvalid_d;
        end
    end

    assign Q      = q_q;
    assign QVALID = qvalid_q;
`else
    assign Q      = rd_data;
    assign QVALID = rvalid_q;
`endif

endmodule

// File: tb/tb_sram_sp_banked.sv
// Scoreboard bench for sram_sp_banked: a behavioural model predicts grants and read data,
// and a negedge monitor compares every DUT output against it.
module tb_sram_sp_banked;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 2048;
    localparam int NUM_BANKS = 4;
    localparam int ADDR_W    = 11;
`ifdef SRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              CLK = 1'b0;
    logic              RST, REQ, WE;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] D;
    logic [3:0]        BE;
    logic              GNT, QVALID, INIT_DONE;
    logic [DATA_W-1:0] Q;

    sram_sp_banked #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .NUM_BANKS (NUM_BANKS)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .WE        (WE),
        .A         (A),
        .D         (D),
        .BE        (BE),
        .GNT       (GNT),
        .Q         (Q),
        .QVALID    (QVALID),
        .INIT_DONE (INIT_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] exp_q_hold = '0;
    logic              model_ready = 1'b0;
    logic              armed = 1'b0;
    int                clr_left = DEPTH;
    int                cyc = 0;
    int                n_cmp = 0;
    int                n_fail = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: memory contents, clear countdown and expected read responses.
    always @(posedge CLK) begin
        cyc++;
        if (RST) begin
            armed       = 1'b1;
            model_ready = 1'b0;
            clr_left    = DEPTH;
            exp_q_hold  = '0;
            sb.delete();
            foreach (model_mem[i]) model_mem[i] = '0;
        end else if (!model_ready) begin
            clr_left--;
            if (clr_left == 0) model_ready = 1'b1;
        end else if (REQ) begin
            if (WE) begin
                for (int b = 0; b < 4; b++)
                    if (BE[b]) model_mem[A][8*b +: 8] = D[8*b +: 8];
            end else begin
                sb.push_back('{data: model_mem[A], due: cyc + LAT - 1});
            end
        end
    end

    // Monitor: handshake, init flag, read responses and Q hold behaviour.
    always @(negedge CLK) begin
        if (armed) begin
            check("gnt", {31'b0, GNT}, {31'b0, REQ && model_ready});
            check("init_done", {31'b0, INIT_DONE}, {31'b0, model_ready});
            if (QVALID) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spurious_qvalid at cycle %0d: got QVALID=1, expected 0", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rd_data", Q, e.data);
                    check("rd_cycle", cyc, e.due);
                    exp_q_hold = e.data;
                end
            end else begin
                check("q_hold", Q, exp_q_hold);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    exp_t e;
                    e = sb.pop_front();
                    n_cmp++;
                    n_fail++;
                    $display("FAIL missing_qvalid at cycle %0d: got QVALID=0, expected read data %h", cyc, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic acc(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [3:0] be);
        REQ = 1'b1;
        WE  = we;
        A   = a;
        D   = d;
        BE  = be;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            REQ = 1'b0;
            WE  = 1'($urandom);
            A   = ADDR_W'($urandom);
            D   = $urandom;
            BE  = 4'($urandom);
            step();
        end
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (!INIT_DONE && n < DEPTH + 16) begin
            step();
            n++;
        end
        if (!INIT_DONE) begin
            n_cmp++;
            n_fail++;
            $display("FAIL init_timeout: INIT_DONE still 0 after %0d cycles, expected 1", n);
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] hot [8];
        logic [ADDR_W-1:0] bnd [6];
        hot = '{11'd0, 11'd7, 11'h123, 11'd511, 11'd512, 11'd1023, 11'd1024, 11'd2047};
        bnd = '{11'd511, 11'd512, 11'd1023, 11'd1024, 11'd1535, 11'd1536};

        RST = 1'b1; REQ = 1'b0; WE = 1'b0; A = '0; D = '0; BE = '0;
        repeat (3) step();

        // Clear with REQ held: reads of address 0 are granted once INIT_DONE rises.
        RST = 1'b0;
        REQ = 1'b1; WE = 1'b0; A = '0;
        wait_init();
        acc(1'b0, 11'd0, '0, '0);
        acc(1'b0, 11'd511, '0, '0);
        acc(1'b0, 11'd512, '0, '0);
        acc(1'b0, 11'd2047, '0, '0);
        idle(2);

        // Byte mask.
        acc(1'b1, 11'h123, 32'hDEADBEEF, 4'b1111);
        acc(1'b1, 11'h123, 32'h11223344, 4'b0101);
        acc(1'b0, 11'h123, '0, '0);
        idle(3);

        // Bank boundaries, read back-to-back.
        for (int i = 0; i < 6; i++) acc(1'b1, bnd[i], DATA_W'(i * 3), 4'hF);
        for (int i = 0; i < 6; i++) acc(1'b0, bnd[i], '0, '0);
        idle(3);

        // Read-after-write, then write isolation between two reads.
        acc(1'b1, 11'd7, 32'hA5A5A5A5, 4'hF);
        acc(1'b0, 11'd7, '0, '0);
        acc(1'b0, 11'h123, '0, '0);
        acc(1'b1, 11'd511, 32'hCAFEF00D, 4'hF);
        acc(1'b1, 11'd512, 32'h0BADC0DE, 4'h0);
        acc(1'b0, 11'd511, '0, '0);
        idle(3);

        // Randomized traffic biased to a few hot addresses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                logic [ADDR_W-1:0] a;
                a = ($urandom_range(0, 1) == 1) ? hot[$urandom_range(0, 7)] : ADDR_W'($urandom);
                acc(1'($urandom), a, $urandom, 4'($urandom));
            end
        end
        idle(3);

        // Reset right after a granted read of a non-zero word; writes during clear are ignored.
        acc(1'b1, 11'h123, 32'h5A5A1234, 4'hF);
        acc(1'b0, 11'h123, '0, '0);
        REQ = 1'b0;
        RST = 1'b1;
        repeat (2) step();
        RST = 1'b0;
        REQ = 1'b1; WE = 1'b1; A = 11'h123; D = 32'hFFFFFFFF; BE = 4'hF;
        repeat (1000) step();
        WE = 1'b0;
        wait_init();
        acc(1'b0, 11'h123, '0, '0);
        acc(1'b0, 11'd7, '0, '0);
        idle(4);

        check("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
